jtag_user_regfile: RTL and testbench
====================================

// Module: jtag_user_regfile
// PURPOSE
//  Parametrised successor to the fixed-width JTAG user chains that drive the board LEDs.
//  One JTAGG user chain (ER1 or ER2) carries framed commands {wr, addr, data} into a bank of
//  NUM_REGS output registers, with readback and error status.
//  Sits between the JTAGG primitive pins and fabric consumers (LED matrix, debug controls).
//  One instance is used per user chain.
// PARAMETERS
//  DATA_W    8   width of each register and of the frame data field
//  ADDR_W    2   width of the frame address field
//  NUM_REGS  4   implemented registers, 1..2**ADDR_W; addresses >= NUM_REGS are out of range
//  RESET_VAL 0   reset/initial value of every register (DATA_W bits)
// PORTS
//  JTCK      in   1                  JTAG clock; the only clock, all state on posedge
//  JRSTN     in   1                  async active-low reset
//  JTDI      in   1                  serial data in
//  JSHIFT    in   1                  TAP in Shift-DR
//  JUPDATE   in   1                  TAP in Update-DR
//  JCE       in   1                  this chain's enable (JCE1 or JCE2)
//  JRTI      in   1                  this chain's Run-Test-Idle flag (JRTI1 or JRTI2)
//  JTDO      out  1                  serial data out (to JTD1/JTD2)
//  regs_out  out  NUM_REGS*DATA_W    register bank, reg i at [i*DATA_W +: DATA_W]
//  wr_strobe out  1                  1-cycle pulse after a committed write
//  wr_addr   out  ADDR_W             address of the last committed write
//  rti_pulse out  1                  1-cycle pulse on first JRTI cycle after a selected update
//  err       out  1                  last update addressed an out-of-range register
// BEHAVIOUR
//  Frame geometry and shift
//  - FRAME_W = 1+ADDR_W+DATA_W. Frame layout: [FRAME_W-1] = wr, [DATA_W +: ADDR_W] = addr,
//    [DATA_W-1:0] = data. The frame is shifted LSB first.
//  - Shift: JCE&JSHIFT -> sr <= {JTDI, sr[FRAME_W-1:1]}. JTDO = sr[0], registered; no logic on the path.
//  Capture
//  - Capture: JCE&!JSHIFT -> sr <= {err, last_addr, reg[last_addr]}.
//  - Capture and shift both set armed=1.
//  Update
//  - Update: JUPDATE&armed; JUPDATE takes priority over JCE in the same cycle.
//    Every update clears armed and sets rti_armed.
//  - In-range write (wr=1, addr<NUM_REGS): reg[addr]<=data, last_addr<=addr, wr_addr<=addr,
//    err<=0, wr_strobe=1 next cycle.
//  - In-range read (wr=0): last_addr<=addr, err<=0, no register change, no strobe.
//  - Out of range (either wr): registers, last_addr and wr_addr unchanged; err<=1; no strobe.
//  - JUPDATE with armed=0 (other chain selected) -> no effect.
//  RTI
//  - rti_pulse=1 for the one cycle after the first JRTI-high cycle with rti_armed=1;
//    this clears rti_armed. Further JRTI cycles -> 0.
//  Reset
//  - JRSTN=0 (async, any time, incl. mid-shift): sr=0, armed=0, rti_armed=0, all regs=RESET_VAL,
//    last_addr=0, wr_addr=0, wr_strobe=0, rti_pulse=0, err=0, JTDO=0.
//  Latency
//  - regs_out changes on the update posedge.
//  - wr_strobe and rti_pulse are registered and appear one cycle after their trigger.
// TESTING
//  Test configuration: DATA_W=8, ADDR_W=2, NUM_REGS=3, RESET_VAL=0; FRAME_W=11.
//  1 Reset, no activity -> regs_out=0, JTDO=0, err=0; capture shifts out 11'h000.
//  2 Shift 11'h4A5 (wr=1, addr=0, data=A5), update -> reg0=A5, wr_strobe one cycle, wr_addr=0.
//    Next capture shifts out 11'h0A5.
//  3 Write 11'h63C (addr=2, data=3C), then read frame 11'h100 (addr=1) ->
//    capture shifts out 11'h100, reg2 still 3C.
//  4 Write to addr 3 (11'h7FF) -> no reg change, no strobe, err=1.
//    Capture shifts out with MSB=1. A valid write then clears err.
//  5 JUPDATE without prior JCE -> nothing changes.
//    JRTI held 3 cycles after a valid update -> rti_pulse exactly once.
//  6 Assert JRSTN low after 5 of 11 shift bits -> all outputs at reset values.
//    Then a full 11-bit frame and update writes correctly (no residue from the partial shift).

Source files
------------

// File: rtl/jtag_user_regfile.sv
`default_nettype none
// ============================================================================
// Module      : jtag_user_regfile
// Description : One JTAGG user chain (ER1/ER2) that carries framed commands
//               {wr, addr, data} into a bank of NUM_REGS output registers.
//               A Capture-DR loads {err, last_addr, reg[last_addr]} for readback,
//               and an Update-DR commits the shifted frame. Frames are shifted
//               LSB first.
// Ports       : JTCK      - JTAG clock, all state on posedge
//               JRSTN     - asynchronous active-low reset
//               JTDI      - serial data in
//               JSHIFT    - TAP in Shift-DR
//               JUPDATE   - TAP in Update-DR
//               JCE       - this chain's enable
//               JRTI      - this chain's Run-Test-Idle flag
//               JTDO      - serial data out, driven straight from the shift register
//               regs_out  - register bank, reg i at [i*DATA_W +: DATA_W]
//               wr_strobe - one-cycle pulse after a committed write
//               wr_addr   - address of the last committed write
//               rti_pulse - one-cycle pulse on the first JRTI cycle after an update
//               err       - last update addressed an out-of-range register
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_user_regfile #(
    parameter int               DATA_W    = 8,
    parameter int               ADDR_W    = 2,
    parameter int               NUM_REGS  = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       JTCK,
    input  logic                       JRSTN,
    input  logic                       JTDI,
    input  logic                       JSHIFT,
    input  logic                       JUPDATE,
    input  logic                       JCE,
    input  logic                       JRTI,
    output logic                       JTDO,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       rti_pulse,
    output logic                       err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;

    // Extra bit so the range compare also works when NUM_REGS == 2**ADDR_W.
    localparam logic [ADDR_W:0] c_num_regs = (ADDR_W+1)'(NUM_REGS);

    logic [FRAME_W-1:0] r_sr;
    logic               r_armed;
    logic               r_rti_armed;
    logic [DATA_W-1:0]  r_regs [NUM_REGS];
    logic [ADDR_W-1:0]  r_last_addr;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic               r_wr_strobe;
    logic               r_rti_pulse;
    logic               r_err;

    logic               w_wr;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_data;
    logic               w_in_range;
    logic [DATA_W-1:0]  w_rd_data;
    logic [FRAME_W-1:0] w_capture;

    // Frame fields as seen at Update-DR.
    assign w_wr       = r_sr[FRAME_W-1];
    assign w_addr     = r_sr[DATA_W +: ADDR_W];
    assign w_data     = r_sr[DATA_W-1:0];
    assign w_in_range = ({1'b0, w_addr} < c_num_regs);

    // Readback mux; last_addr only ever holds an in-range address.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_last_addr == ADDR_W'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    assign w_capture = {r_err, r_last_addr, w_rd_data};

    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            r_sr        <= '0;
            r_armed     <= 1'b0;
            r_rti_armed <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
            r_last_addr <= '0;
            r_wr_addr   <= '0;
            r_wr_strobe <= 1'b0;
            r_rti_pulse <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wr_strobe <= 1'b0;
            r_rti_pulse <= 1'b0;

            if (JRTI && r_rti_armed) begin
                r_rti_pulse <= 1'b1;
                r_rti_armed <= 1'b0;
            end

            // Update-DR wins over capture/shift. Without a preceding
            // capture/shift on this chain (armed=0) the update belongs to
            // the other chain and is ignored.
            if (JUPDATE) begin
                if (r_armed) begin
                    r_armed     <= 1'b0;
                    r_rti_armed <= 1'b1;
                    if (w_in_range) begin
                        r_last_addr <= w_addr;
                        r_err       <= 1'b0;
                        if (w_wr) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (w_addr == ADDR_W'(i)) begin
                                    r_regs[i] <= w_data;
                                end
                            end
                            r_wr_addr   <= w_addr;
                            r_wr_strobe <= 1'b1;
                        end
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            end else if (JCE) begin
                r_armed <= 1'b1;
                if (JSHIFT) begin
                    r_sr <= {JTDI, r_sr[FRAME_W-1:1]};
                end else begin
                    r_sr <= w_capture;
                end
            end
        end
    end

    // JTDO comes straight off a flop so TDO timing stays clean.
    assign JTDO      = r_sr[0];
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign rti_pulse = r_rti_pulse;
    assign err       = r_err;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pack
            assign regs_out[gi*DATA_W +: DATA_W] = r_regs[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_jtag_user_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_user_regfile
// Description : Self-checking bench for jtag_user_regfile (DATA_W=8, ADDR_W=2,
//               NUM_REGS=3). Directed scenarios plus random frames, checked
//               against a register-bank model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_user_regfile;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int NR = 3;
    localparam int FW = 11;

    logic          JTCK    = 1'b0;
    logic          JRSTN   = 1'b0;
    logic          JTDI    = 1'b0;
    logic          JSHIFT  = 1'b0;
    logic          JUPDATE = 1'b0;
    logic          JCE     = 1'b0;
    logic          JRTI    = 1'b0;
    logic          JTDO;
    logic [NR*DW-1:0] regs_out;
    logic          wr_strobe;
    logic [AW-1:0] wr_addr;
    logic          rti_pulse;
    logic          err;

    jtag_user_regfile #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_REGS (NR),
        .RESET_VAL(8'h00)
    ) u_dut (
        .JTCK     (JTCK),
        .JRSTN    (JRSTN),
        .JTDI     (JTDI),
        .JSHIFT   (JSHIFT),
        .JUPDATE  (JUPDATE),
        .JCE      (JCE),
        .JRTI     (JRTI),
        .JTDO     (JTDO),
        .regs_out (regs_out),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .rti_pulse(rti_pulse),
        .err      (err)
    );

    always #5 JTCK = ~JTCK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a plain register array plus status.
    logic [DW-1:0] m_regs [NR];
    logic          m_err;
    logic [AW-1:0] m_last;
    logic [AW-1:0] m_waddr;
    logic          m_strobe;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] m_pack();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) r = r | (32'(m_regs[i]) << (i*DW));
        return r;
    endfunction

    function automatic logic [10:0] m_capture();
        return {m_err, m_last, m_regs[m_last]};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        m_err = 1'b0; m_last = '0; m_waddr = '0; m_strobe = 1'b0;
    endtask

    task automatic m_update(input logic [10:0] f);
        int a;
        a = int'(f[9:8]);
        m_strobe = 1'b0;
        if (a < NR) begin
            m_last = f[9:8];
            m_err  = 1'b0;
            if (f[10]) begin
                m_regs[a] = f[7:0];
                m_waddr   = f[9:8];
                m_strobe  = 1'b1;
            end
        end else begin
            m_err = 1'b1;
        end
    endtask

    // Capture-DR, 11 Shift-DR cycles, Update-DR. Returns the bits seen on JTDO.
    task automatic scan(input logic [10:0] f, output logic [10:0] cap);
        @(negedge JTCK); JCE = 1'b1; JSHIFT = 1'b0;
        @(posedge JTCK);
        for (int i = 0; i < FW; i++) begin
            @(negedge JTCK);
            cap[i] = JTDO;
            JSHIFT = 1'b1;
            JTDI   = f[i];
            @(posedge JTCK);
        end
        @(negedge JTCK); JCE = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b1;
        @(posedge JTCK);
        @(negedge JTCK); JUPDATE = 1'b0;
    endtask

    task automatic scan_check(input logic [10:0] f, input string tag);
        logic [10:0] cap;
        logic [10:0] exp_cap;
        exp_cap = m_capture();
        scan(f, cap);
        m_update(f);
        check({tag, ".cap"},    32'(cap),       32'(exp_cap));
        check({tag, ".regs"},   32'(regs_out),  m_pack());
        check({tag, ".err"},    32'(err),       32'(m_err));
        check({tag, ".waddr"},  32'(wr_addr),   32'(m_waddr));
        check({tag, ".strobe"}, 32'(wr_strobe), 32'(m_strobe));
        @(negedge JTCK);
        check({tag, ".strobe_end"}, 32'(wr_strobe), 32'd0);
    endtask

    initial begin
        logic [10:0] cap;
        logic [10:0] f;

        m_reset();
        repeat (3) @(negedge JTCK);
        JRSTN = 1'b1;
        @(negedge JTCK);

        // 1: reset state
        check("rst.regs", 32'(regs_out), 32'd0);
        check("rst.jtdo", 32'(JTDO), 32'd0);
        check("rst.err",  32'(err), 32'd0);
        check("rst.strobe", 32'(wr_strobe), 32'd0);
        check("rst.rti",  32'(rti_pulse), 32'd0);
        scan(11'h100, cap);             // read addr 1
        m_update(11'h100);
        check("t1.cap", 32'(cap), 32'h000);

        // 2: write A5 to reg0, then read it back
        scan_check(11'h4A5, "t2.wr");
        check("t2.reg0", 32'(regs_out[7:0]), 32'hA5);
        scan_check(11'h000, "t2.rd");   // shows 0A5 via last_addr=0

        // 3: write reg2, read addr1
        scan_check(11'h63C, "t3.wr");
        scan_check(11'h100, "t3.rd");
        scan(11'h000, cap);
        m_update(11'h000);
        check("t3.cap", 32'(cap), 32'h100);
        check("t3.reg2", 32'(regs_out[23:16]), 32'h3C);

        // 4: out-of-range write, then valid write clears err
        scan_check(11'h7FF, "t4.oor");
        check("t4.err", 32'(err), 32'd1);
        scan(11'h512, cap);
        check("t4.cap_msb", 32'(cap[10]), 32'd1);
        m_update(11'h512);
        check("t4.clr", 32'(err), 32'd0);
        check("t4.reg1", 32'(regs_out[15:8]), 32'h12);

        // 5: stray JUPDATE without this chain selected, then RTI pulse
        @(negedge JTCK); JUPDATE = 1'b1;
        @(negedge JTCK); JUPDATE = 1'b0;
        check("t5.regs", 32'(regs_out), m_pack());
        check("t5.err",  32'(err), 32'(m_err));
        check("t5.strobe", 32'(wr_strobe), 32'd0);
        scan_check(11'h0C0 | 11'h400, "t5.wr");
        JRTI = 1'b1;
        @(negedge JTCK); check("t5.rti1", 32'(rti_pulse), 32'd1);
        @(negedge JTCK); check("t5.rti2", 32'(rti_pulse), 32'd0);
        @(negedge JTCK); check("t5.rti3", 32'(rti_pulse), 32'd0);
        JRTI = 1'b0;

        // Random frames, including out-of-range addresses and reads
        for (int n = 0; n < 40; n++) begin
            f = 11'($urandom_range(0, 2047));
            scan_check(f, "rnd");
            if ($urandom_range(0, 3) == 0) begin
                JRTI = 1'b1;
                @(negedge JTCK); check("rnd.rti_hi", 32'(rti_pulse), 32'd1);
                @(negedge JTCK); check("rnd.rti_lo", 32'(rti_pulse), 32'd0);
                JRTI = 1'b0;
            end
        end

        // 6: reset in the middle of a shift
        scan_check(11'h6AA, "t6.pre");  // leaves wr_addr=2, reg2=AA
        @(negedge JTCK); JCE = 1'b1; JSHIFT = 1'b0;
        @(posedge JTCK);
        for (int i = 0; i < 5; i++) begin
            @(negedge JTCK); JSHIFT = 1'b1; JTDI = 1'b1;
            @(posedge JTCK);
        end
        @(negedge JTCK);
        #2 JRSTN = 1'b0;
        #1;
        m_reset();
        check("t6.regs",   32'(regs_out), 32'd0);
        check("t6.jtdo",   32'(JTDO), 32'd0);
        check("t6.err",    32'(err), 32'd0);
        check("t6.waddr",  32'(wr_addr), 32'd0);
        check("t6.strobe", 32'(wr_strobe), 32'd0);
        check("t6.rti",    32'(rti_pulse), 32'd0);
        @(negedge JTCK);
        JCE = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0;
        JRSTN = 1'b1;
        @(negedge JTCK);
        scan_check(11'h55A, "t6.post");
        check("t6.reg1", 32'(regs_out[15:8]), 32'h5A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
